// File: rtl/seq_alu_pkg.sv
// Shared ALU definitions: the 5-bit opcode set (original 16 plus USB/SSB/UDV/SDV),
// the sequencer state encoding and small opcode classifiers.
package seq_alu_pkg;

    localparam logic [4:0] ALU_PUR = 5'd0;
    localparam logic [4:0] ALU_SHL = 5'd1;
    localparam logic [4:0] ALU_SHR = 5'd2;
    localparam logic [4:0] ALU_UNC = 5'd3;
    localparam logic [4:0] ALU_EQ  = 5'd4;
    localparam logic [4:0] ALU_ULT = 5'd5;
    localparam logic [4:0] ALU_SLT = 5'd6;
    localparam logic [4:0] ALU_ULE = 5'd7;
    localparam logic [4:0] ALU_SLE = 5'd8;
    localparam logic [4:0] ALU_UAD = 5'd9;
    localparam logic [4:0] ALU_SAD = 5'd10;
    localparam logic [4:0] ALU_AND = 5'd11;
    localparam logic [4:0] ALU_OR  = 5'd12;
    localparam logic [4:0] ALU_XOR = 5'd13;
    localparam logic [4:0] ALU_UMT = 5'd14;
    localparam logic [4:0] ALU_SMT = 5'd15;
    localparam logic [4:0] ALU_USB = 5'd16;
    localparam logic [4:0] ALU_SSB = 5'd17;
    localparam logic [4:0] ALU_UDV = 5'd18;
    localparam logic [4:0] ALU_SDV = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == ALU_UMT) || (op == ALU_SMT);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_UDV) || (op == ALU_SDV);
    endfunction

    function automatic logic is_signed_iter_op(input logic [4:0] op);
        return (op == ALU_SMT) || (op == ALU_SDV);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the calculator control FSM (master) and seq_alu (slave).
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [4:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             arithmetic_overflow;
    logic             shift_overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, operand_a, operand_b, alu_op, out_ready,
        input  in_ready, out_valid, result, result_hi,
               arithmetic_overflow, shift_overflow, div_by_zero
    );

    modport slave (
        input  in_valid, operand_a, operand_b, alu_op, out_ready,
        output in_ready, out_valid, result, result_hi,
               arithmetic_overflow, shift_overflow, div_by_zero
    );
endinterface

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: right-shifting shift-add multiply and restoring divide
// on unsigned magnitudes. lo_next/hi_next expose the value after the current step.
module seq_alu_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic             div_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign last = (cnt_reg == CNT_W'(WIDTH - 1));

    // Remainder stays below the divisor, so the trial value fits in WIDTH+1 bits
    // and the top bit of the difference is a clean borrow.
    always_comb begin
        add_sum = {1'b0, acc_reg} + (sh_reg[0] ? {1'b0, opnd_reg} : '0);
        trial   = {acc_reg, sh_reg[WIDTH-1]};
        diff    = trial - {1'b0, opnd_reg};
        if (div_reg) begin
            if (diff[WIDTH]) begin
                hi_next = trial[WIDTH-1:0];
                lo_next = {sh_reg[WIDTH-2:0], 1'b0};
            end else begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {sh_reg[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_next = add_sum[WIDTH:1];
            lo_next = {add_sum[0], sh_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            sh_reg   <= '0;
            opnd_reg <= '0;
            div_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else if (load) begin
            acc_reg  <= '0;
            sh_reg   <= a_mag;
            opnd_reg <= b_mag;
            div_reg  <= load_div;
            cnt_reg  <= '0;
        end else if (step) begin
            acc_reg  <= hi_next;
            sh_reg   <= lo_next;
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops resolve at acceptance, multiply/divide iterate
// WIDTH cycles in seq_alu_iter; results are held in DONE until the consumer takes them.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic    clk,
    input logic    rst,
    seq_alu_if.slave bus
);
    alu_state_t state_reg, state_next;

    logic [4:0]       op_reg, op_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic             ovf_pend_reg, ovf_pend_next;
    logic             in_ready_reg, in_ready_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] result_hi_reg, result_hi_next;
    logic             aov_reg, aov_next;
    logic             sov_reg, sov_next;
    logic             dbz_reg, dbz_next;

    logic             it_load, it_load_div, it_step, it_last;
    logic [WIDTH-1:0] it_lo, it_hi, a_mag, b_mag;
    logic             a_neg, b_neg, signed_op;

    logic [WIDTH-1:0] a, b, and_vec, or_vec, xor_vec;
    logic [WIDTH:0]   add_u, sub_u, add_s, sub_s;
    logic [WIDTH-1:0] sc_res;
    logic             sc_aov, sc_sov;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign a = bus.operand_a;
    assign b = bus.operand_b;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_vec[gi] = a[gi] & b[gi];
            assign or_vec[gi]  = a[gi] | b[gi];
            assign xor_vec[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    assign add_u = {1'b0, a} + {1'b0, b};
    assign sub_u = {1'b0, a} - {1'b0, b};
    assign add_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign sub_s = {a[WIDTH-1], a} - {b[WIDTH-1], b};

    always_comb begin
        sc_res = a;
        sc_aov = 1'b0;
        sc_sov = 1'b0;
        case (bus.alu_op)
            ALU_SHL: begin sc_res = {a[WIDTH-2:0], 1'b0}; sc_sov = a[WIDTH-1]; end
            ALU_SHR: begin sc_res = {1'b0, a[WIDTH-1:1]}; sc_sov = a[0]; end
            ALU_UNC: sc_res = WIDTH'(1'b1);
            ALU_EQ:  sc_res = WIDTH'(a == b);
            ALU_ULT: sc_res = WIDTH'(a < b);
            ALU_SLT: sc_res = WIDTH'($signed(a) < $signed(b));
            ALU_ULE: sc_res = WIDTH'(a <= b);
            ALU_SLE: sc_res = WIDTH'($signed(a) <= $signed(b));
            ALU_UAD: begin sc_res = add_u[WIDTH-1:0]; sc_aov = add_u[WIDTH]; end
            ALU_SAD: begin sc_res = add_s[WIDTH-1:0]; sc_aov = add_s[WIDTH] ^ add_s[WIDTH-1]; end
            ALU_USB: begin sc_res = sub_u[WIDTH-1:0]; sc_aov = sub_u[WIDTH]; end
            ALU_SSB: begin sc_res = sub_s[WIDTH-1:0]; sc_aov = sub_s[WIDTH] ^ sub_s[WIDTH-1]; end
            ALU_AND: sc_res = and_vec;
            ALU_OR:  sc_res = or_vec;
            ALU_XOR: sc_res = xor_vec;
            default: sc_res = a;
        endcase
    end

    // The iterator only ever sees magnitudes; signs are reapplied on the final step.
    assign signed_op = is_signed_iter_op(bus.alu_op);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;

    seq_alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (it_load),
        .load_div (it_load_div),
        .step     (it_step),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .last     (it_last),
        .lo_next  (it_lo),
        .hi_next  (it_hi)
    );

    assign prod = neg_q_reg ? -{it_hi, it_lo} : {it_hi, it_lo};
    assign quo  = neg_q_reg ? -it_lo : it_lo;
    assign rem  = neg_r_reg ? -it_hi : it_hi;

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        neg_q_next     = neg_q_reg;
        neg_r_next     = neg_r_reg;
        ovf_pend_next  = ovf_pend_reg;
        result_next    = result_reg;
        result_hi_next = result_hi_reg;
        aov_next       = aov_reg;
        sov_next       = sov_reg;
        dbz_next       = dbz_reg;
        it_load        = 1'b0;
        it_load_div    = 1'b0;
        it_step        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_reg) begin
                    op_next       = bus.alu_op;
                    neg_q_next    = a_neg ^ b_neg;
                    neg_r_next    = a_neg;
                    ovf_pend_next = (bus.alu_op == ALU_SDV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                    if (is_mul_op(bus.alu_op)) begin
                        it_load    = 1'b1;
                        state_next = ST_MUL;
                    end else if (is_div_op(bus.alu_op) && (b == '0)) begin
                        result_next    = '1;
                        result_hi_next = a;
                        aov_next       = 1'b0;
                        sov_next       = 1'b0;
                        dbz_next       = 1'b1;
                        state_next     = ST_DONE;
                    end else if (is_div_op(bus.alu_op)) begin
                        it_load     = 1'b1;
                        it_load_div = 1'b1;
                        state_next  = ST_DIV;
                    end else begin
                        result_next    = sc_res;
                        result_hi_next = '0;
                        aov_next       = sc_aov;
                        sov_next       = sc_sov;
                        dbz_next       = 1'b0;
                        state_next     = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                it_step = 1'b1;
                if (it_last) begin
                    result_next    = prod[WIDTH-1:0];
                    result_hi_next = prod[2*WIDTH-1:WIDTH];
                    aov_next       = (op_reg == ALU_SMT)
                                   ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                   : (prod[2*WIDTH-1:WIDTH] != '0);
                    sov_next       = 1'b0;
                    dbz_next       = 1'b0;
                    state_next     = ST_DONE;
                end
            end
            ST_DIV: begin
                it_step = 1'b1;
                if (it_last) begin
                    result_next    = quo;
                    result_hi_next = rem;
                    aov_next       = ovf_pend_reg;
                    sov_next       = 1'b0;
                    dbz_next       = 1'b0;
                    state_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        in_ready_next  = (state_next == ST_IDLE);
        out_valid_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            ovf_pend_reg  <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            aov_reg       <= 1'b0;
            sov_reg       <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            neg_q_reg     <= neg_q_next;
            neg_r_reg     <= neg_r_next;
            ovf_pend_reg  <= ovf_pend_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            result_hi_reg <= result_hi_next;
            aov_reg       <= aov_next;
            sov_reg       <= sov_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign bus.in_ready            = in_ready_reg;
    assign bus.out_valid           = out_valid_reg;
    assign bus.result              = result_reg;
    assign bus.result_hi           = result_hi_reg;
    assign bus.arithmetic_overflow = aov_reg;
    assign bus.shift_overflow      = sov_reg;
    assign bus.div_by_zero         = dbz_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): directed cases, backpressure, mid-op reset
// and randomized traffic checked against an integer-arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] res, hi;
        logic         aov, sov, dbz;
        int           lat;
        int           acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   rand_rdy = 1'b0;
    bit   forced_rdy = 1'b1;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_alu_if #(.WIDTH(W)) bus();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        exp_t e;
        longint full  = longint'(1) << W;
        longint mask  = full - 1;
        longint half  = full >> 1;
        longint mask2 = (longint'(1) << (2 * W)) - 1;
        longint a = longint'(a_in);
        longint b = longint'(b_in);
        longint sa = (a >= half) ? a - full : a;
        longint sb = (b >= half) ? b - full : b;
        longint r = 0, h = 0, p = 0;
        e.op = op; e.a = a_in; e.b = b_in;
        e.aov = 0; e.sov = 0; e.dbz = 0; e.lat = 1; e.acc_cyc = 0;
        case (op)
            ALU_SHL: begin r = (a * 2) & mask; e.sov = (a >= half); end
            ALU_SHR: begin r = a / 2; e.sov = (a % 2) == 1; end
            ALU_UNC: r = 1;
            ALU_EQ:  r = (a == b) ? 1 : 0;
            ALU_ULT: r = (a < b) ? 1 : 0;
            ALU_SLT: r = (sa < sb) ? 1 : 0;
            ALU_ULE: r = (a <= b) ? 1 : 0;
            ALU_SLE: r = (sa <= sb) ? 1 : 0;
            ALU_UAD: begin p = a + b; r = p & mask; e.aov = (p >= full); end
            ALU_SAD: begin p = sa + sb; r = p & mask; e.aov = (p >= half) || (p < -half); end
            ALU_USB: begin p = a - b; r = p & mask; e.aov = (a < b); end
            ALU_SSB: begin p = sa - sb; r = p & mask; e.aov = (p >= half) || (p < -half); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_UMT: begin p = a * b; r = p & mask; h = p >> W; e.aov = (h != 0); e.lat = W + 1; end
            ALU_SMT: begin
                p = sa * sb; r = p & mask; h = (p & mask2) >> W;
                e.aov = (p >= half) || (p < -half); e.lat = W + 1;
            end
            ALU_UDV, ALU_SDV: begin
                if (b == 0) begin
                    r = mask; h = a; e.dbz = 1;
                end else if (op == ALU_UDV) begin
                    r = a / b; h = a % b; e.lat = W + 1;
                end else if (sa == -half && sb == -1) begin
                    r = half; h = 0; e.aov = 1; e.lat = W + 1;
                end else begin
                    r = (sa / sb) & mask; h = (sa % sb) & mask; e.lat = W + 1;
                end
            end
            default: r = a;
        endcase
        e.res = r[W-1:0];
        e.hi  = h[W-1:0];
        return e;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
        int   waited = 0;
        exp_t e;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.alu_op = op; bus.operand_a = a; bus.operand_b = b;
        @(negedge clk);
        while (!(bus.in_ready === 1'b1 && rst === 1'b0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            n_checks++;
            $display("FAIL accept_timeout: waited %0d cycles for in_ready, required fewer than 200", waited);
            bus.in_valid = 1'b0;
            return;
        end
        if (expect_it) begin
            e = model(op, a, b);
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.operand_a = W'($urandom); bus.operand_b = W'($urandom); bus.alu_op = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || bus.out_valid !== 1'b0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results still pending after %0d cycles, required 0", sb_q.size(), n);
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    // out_ready driver: the only writer of bus.out_ready
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : forced_rdy;
        end
    end

    // Monitor: one comparison set per presented result, then hold-stability while stalled.
    initial begin
        bit   seen = 1'b0;
        exp_t e;
        logic [2*W+2:0] held = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                seen = 1'b0;
            end else if (bus.out_valid === 1'b1) begin
                chk("done_in_ready", bus.in_ready, 0);
                if (!seen) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_result", bus.out_valid, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("result", bus.result, e.res);
                        chk("result_hi", bus.result_hi, e.hi);
                        chk("arith_ovf", bus.arithmetic_overflow, e.aov);
                        chk("shift_ovf", bus.shift_overflow, e.sov);
                        chk("div_by_zero", bus.div_by_zero, e.dbz);
                        chk("latency", cyc - e.acc_cyc, e.lat);
                        $display("txn op=%0d a=%0h b=%0h -> result=%0h hi=%0h aov=%0b sov=%0b dbz=%0b lat=%0d",
                                 e.op, e.a, e.b, bus.result, bus.result_hi, bus.arithmetic_overflow,
                                 bus.shift_overflow, bus.div_by_zero, cyc - e.acc_cyc);
                    end
                    held = {bus.result, bus.result_hi, bus.arithmetic_overflow, bus.shift_overflow, bus.div_by_zero};
                end else begin
                    chk("hold_stable", {bus.result, bus.result_hi, bus.arithmetic_overflow,
                                        bus.shift_overflow, bus.div_by_zero}, held);
                end
                seen = !bus.out_ready;
            end
        end
    end

    initial begin
        logic [4:0]   d_op [11] = '{ALU_UAD, ALU_SMT, ALU_UMT, ALU_SDV, ALU_UDV, ALU_UDV, ALU_SDV,
                                    ALU_SSB, ALU_SHR, ALU_SLT, 5'd27};
        logic [W-1:0] d_a  [11] = '{8'd200, 8'hFD, 8'd16, 8'hF9, 8'd200, 8'd5, 8'h80,
                                    8'h80, 8'h03, 8'hFF, 8'h5A};
        logic [W-1:0] d_b  [11] = '{8'd100, 8'd5, 8'd32, 8'd2, 8'd7, 8'd0, 8'hFF,
                                    8'h01, 8'h00, 8'h01, 8'h11};
        bus.in_valid = 1'b0; bus.operand_a = '0; bus.operand_b = '0; bus.alu_op = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_outputs", {bus.result, bus.result_hi, bus.arithmetic_overflow, bus.shift_overflow, bus.div_by_zero}, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 11; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1);
        drain();

        // Backpressure: hold the UMT result for 5 cycles while another op waits.
        forced_rdy = 1'b0;
        @(posedge clk);
        issue(ALU_UMT, 8'd16, 8'd32, 1'b1);
        fork
            issue(ALU_UAD, 8'd200, 8'd100, 1'b1);
            begin
                int n = 0;
                while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
                chk("bp_wait_valid", bus.out_valid, 1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", bus.in_ready, 0);
                    chk("bp_out_valid", bus.out_valid, 1);
                end
                forced_rdy = 1'b1;
            end
        join
        drain();

        // Reset three cycles into a divide: the op must vanish without a result.
        issue(ALU_UDV, 8'd200, 8'd7, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_outputs", {bus.result, bus.result_hi, bus.arithmetic_overflow, bus.shift_overflow, bus.div_by_zero}, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        repeat (12) @(posedge clk);
        issue(ALU_SHL, 8'h81, 8'h00, 1'b1);
        drain();

        // Randomized traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(5'($urandom_range(0, 31)), rand_operand(), rand_operand(), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        drain();
        rand_rdy = 1'b0;
        forced_rdy = 1'b1;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
